// File: rtl/apb_counter_arbiter_if.sv
// Requester command/response signals and the shared APB bus for apb_counter_arbiter.
// master: the arbiter side. slave: requesters plus the APB counter slave.
interface apb_counter_arbiter_if;
  logic        req0;
  logic        req1;
  logic        wr0;
  logic        wr1;
  logic [3:0]  addr0;
  logic [3:0]  addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic        err0;
  logic        err1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, PRDATA, PREADY,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, PRDATA, PREADY,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_counter_arbiter.sv
// Two-requester APB master: round-robin arbitration onto one APB slave,
// SETUP/ACCESS transfer, per-requester read data and done/err pulses,
// optional abort when PREADY stays low for too long.
module apb_counter_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd16
) (
  input logic                  clk,
  input logic                  rst,
  apb_counter_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t     state;
  logic       last;
  logic       owner;
  logic [7:0] wait_cnt;
  logic       elig0;
  logic       elig1;
  logic       pick;

  // Eligibility masks a request on its own done cycle; tie goes to the requester not served last.
  always_comb begin
    elig0 = bus.req0 & ~bus.done0;
    elig1 = bus.req1 & ~bus.done1;
    pick  = 1'b0;
    if (elig0 && elig1) pick = ~last;
    else if (elig1)     pick = 1'b1;
  end

  // Transfer FSM with all bus and requester outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= 1'b0;
      wait_cnt    <= '0;
      bus.PSEL    <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
      bus.err0    <= 1'b0;
      bus.err1    <= 1'b0;
      bus.rdata0  <= '0;
      bus.rdata1  <= '0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.err0  <= 1'b0;
      bus.err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            owner       <= pick;
            last        <= pick;
            bus.gnt0    <= ~pick;
            bus.gnt1    <= pick;
            bus.PWRITE  <= pick ? bus.wr1    : bus.wr0;
            bus.PADDR   <= pick ? bus.addr1  : bus.addr0;
            bus.PWDATA  <= pick ? bus.wdata1 : bus.wdata0;
            bus.PSEL    <= 1'b1;
            bus.PENABLE <= 1'b0;
            wait_cnt    <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            state       <= IDLE;
            if (owner) begin
              bus.done1 <= 1'b1;
              if (!bus.PWRITE) bus.rdata1 <= bus.PRDATA;
            end else begin
              bus.done0 <= 1'b1;
              if (!bus.PWRITE) bus.rdata0 <= bus.PRDATA;
            end
          end else if ((TIMEOUT != 8'd0) && (wait_cnt == TIMEOUT)) begin
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            state       <= IDLE;
            if (owner) begin
              bus.done1  <= 1'b1;
              bus.err1   <= 1'b1;
              bus.rdata1 <= '0;
            end else begin
              bus.done0  <= 1'b1;
              bus.err0   <= 1'b1;
              bus.rdata0 <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_counter_arbiter.sv
// Self-checking bench for apb_counter_arbiter with a behavioural APB counter slave.
module tb_apb_counter_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  apb_counter_arbiter_if bus  ();
  apb_counter_arbiter_if bus4 ();
  apb_counter_arbiter_if bus0 ();

  apb_counter_arbiter #(.TIMEOUT(8'd16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  apb_counter_arbiter #(.TIMEOUT(8'd4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
  apb_counter_arbiter #(.TIMEOUT(8'd0))  dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  // Counter slave state: 0 load value, 1 load (bit0 loads), 2 enable (bit0), 3 count.
  logic [31:0] s_reg0 = '0, s_reg1 = '0, s_reg2 = '0, s_cnt = '0, s_last_read = '0;
  int s_wait_left = 0;
  int cfg_waits   = 0;
  bit rand_waits  = 1'b0;
  int b4_waits    = 0;
  int b4_left     = 0;

  // Slave response for the main bus: wait states chosen during SETUP, PREADY noise outside ACCESS.
  always @(negedge clk) begin
    if (bus.PSEL && !bus.PENABLE) s_wait_left = rand_waits ? int'($urandom_range(0, 3)) : cfg_waits;
    if (bus.PSEL && bus.PENABLE) begin
      if (s_wait_left > 0) begin
        bus.PREADY = 1'b0;
        s_wait_left--;
      end else bus.PREADY = 1'b1;
    end else bus.PREADY = 1'($urandom_range(0, 1));
    case (bus.PADDR)
      4'd0:    bus.PRDATA = s_reg0;
      4'd1:    bus.PRDATA = s_reg1;
      4'd2:    bus.PRDATA = s_reg2;
      4'd3:    bus.PRDATA = s_cnt;
      default: bus.PRDATA = '0;
    endcase
  end

  // Slave register update on a completed APB transfer; free-running count when enabled.
  always @(posedge clk) begin
    if (s_reg2[0]) s_cnt = s_cnt + 1;
    if (!rst && bus.PSEL && bus.PENABLE && bus.PREADY) begin
      if (bus.PWRITE) begin
        case (bus.PADDR)
          4'd0: s_reg0 = bus.PWDATA;
          4'd1: begin s_reg1 = bus.PWDATA; if (bus.PWDATA[0]) s_cnt = s_reg0; end
          4'd2: s_reg2 = bus.PWDATA;
          4'd3: s_cnt = bus.PWDATA;
          default: ;
        endcase
      end else s_last_read = bus.PRDATA;
    end
  end

  // Slave for the TIMEOUT=4 instance: b4_waits low cycles then ready, negative means never ready.
  always @(negedge clk) begin
    if (bus4.PSEL && !bus4.PENABLE) b4_left = b4_waits;
    if (bus4.PSEL && bus4.PENABLE) begin
      if (b4_waits < 0) bus4.PREADY = 1'b0;
      else if (b4_left > 0) begin
        bus4.PREADY = 1'b0;
        b4_left--;
      end else bus4.PREADY = 1'b1;
    end else bus4.PREADY = 1'b0;
  end

  task automatic drive_cmd(input int r, input bit rq, input bit w, input logic [3:0] a, input logic [31:0] d);
    if (r == 0) begin
      bus.req0 = rq; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = rq; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic run_req(input int r, input bit w, input logic [3:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    drive_cmd(r, 1'b1, w, a, d);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if ((r == 0 && bus.done0) || (r == 1 && bus.done1)) begin
        lat = n;
        break;
      end
    end
    drive_cmd(r, 1'b0, w, a, d);
  endtask

  task automatic new_cmd(input int r, output bit w, output logic [3:0] a, output logic [31:0] d);
    w = 1'($urandom_range(0, 1));
    a = 4'($urandom_range(0, 3));
    d = $urandom;
    if (w && a == 4'd2) d[0] = 1'b0;
    drive_cmd(r, 1'b1, w, a, d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1} !== 9'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b want=0", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1}); end
    checks++;
    if (bus.PADDR !== 4'd0 || bus.PWDATA !== 32'd0)
      begin failures++; $display("FAIL reset_bus got PADDR=%0h PWDATA=%0h want 0", bus.PADDR, bus.PWDATA); end
    checks++;
    if (bus.rdata0 !== 32'd0 || bus.rdata1 !== 32'd0)
      begin failures++; $display("FAIL reset_rdata got %0h %0h want 0", bus.rdata0, bus.rdata1); end
    checks++;
    if (bus4.PSEL !== 1'b0 || bus0.PSEL !== 1'b0)
      begin failures++; $display("FAIL reset_psel_other got %b %b want 0", bus4.PSEL, bus0.PSEL); end
    rst = 1'b0;
  endtask

  task automatic test_write;
    int lat = 0;
    cfg_waits = 0;
    @(negedge clk);
    drive_cmd(0, 1'b1, 1'b1, 4'd0, 32'h0000_0010);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.gnt0, bus.gnt1, bus.PWRITE} !== 5'b10101)
          begin failures++; $display("FAIL write_setup got=%b want=10101", {bus.PSEL, bus.PENABLE, bus.gnt0, bus.gnt1, bus.PWRITE}); end
        checks++;
        if (bus.PADDR !== 4'd0 || bus.PWDATA !== 32'h10)
          begin failures++; $display("FAIL write_addr_data got %0h/%0h want 0/10", bus.PADDR, bus.PWDATA); end
      end
      if (n == 2) begin
        checks++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11)
          begin failures++; $display("FAIL write_access got=%b want=11", {bus.PSEL, bus.PENABLE}); end
      end
      if (bus.done0) begin lat = n; break; end
    end
    drive_cmd(0, 1'b0, 1'b1, 4'd0, 32'h0000_0010);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL write_latency got=%0d want=3", lat); end
    checks++;
    if (bus.err0 !== 1'b0 || bus.done1 !== 1'b0 || bus.PSEL !== 1'b0 || bus.gnt0 !== 1'b0)
      begin failures++; $display("FAIL write_done_state err0=%b done1=%b PSEL=%b gnt0=%b want 0", bus.err0, bus.done1, bus.PSEL, bus.gnt0); end
    @(negedge clk);
    checks++;
    if (bus.done0 !== 1'b0 || bus.PADDR !== 4'd0 || bus.PWDATA !== 32'h10 || bus.PENABLE !== 1'b0)
      begin failures++; $display("FAIL write_idle_hold done0=%b PADDR=%0h PWDATA=%0h want 0/0/10", bus.done0, bus.PADDR, bus.PWDATA); end
  endtask

  task automatic test_read;
    int lat;
    int extra = 0;
    run_req(0, 1'b1, 4'd1, 32'd1, lat);
    run_req(0, 1'b1, 4'd1, 32'd0, lat);
    run_req(0, 1'b1, 4'd2, 32'd1, lat);
    repeat (5) @(negedge clk);
    run_req(1, 1'b0, 4'd3, 32'd0, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL read_latency got=%0d want=3", lat); end
    checks++;
    if (bus.rdata1 !== s_last_read || bus.rdata1 < 32'h10)
      begin failures++; $display("FAIL read_count got=%0h want=%0h (>=10)", bus.rdata1, s_last_read); end
    repeat (8) begin
      @(negedge clk);
      if (bus.done1) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL read_single_done extra=%0d want=0", extra); end
    run_req(0, 1'b1, 4'd2, 32'd0, lat);
  endtask

  task automatic test_wait_states;
    int lat;
    cfg_waits = 3;
    run_req(0, 1'b0, 4'd0, 32'd0, lat);
    cfg_waits = 0;
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL wait_latency got=%0d want=6", lat); end
    checks++;
    if (bus.rdata0 !== 32'h10 || bus.err0 !== 1'b0)
      begin failures++; $display("FAIL wait_rdata got=%0h err=%b want=10 err=0", bus.rdata0, bus.err0); end
  endtask

  task automatic test_back_to_back;
    int cyc = 0, d_cyc = -1, gap = -1, ndone = 0;
    logic [31:0] first_rd = '0;
    bit pg = 1'b0;
    @(negedge clk);
    drive_cmd(0, 1'b1, 1'b0, 4'd0, 32'd0);
    for (int n = 0; n < 60 && ndone < 2; n++) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt0 && !pg && d_cyc >= 0) gap = cyc - d_cyc;
      pg = bus.gnt0;
      if (bus.done0) begin
        ndone++;
        if (ndone == 1) begin
          d_cyc = cyc;
          first_rd = bus.rdata0;
          drive_cmd(0, 1'b1, 1'b0, 4'd2, 32'd0);
        end else drive_cmd(0, 1'b0, 1'b0, 4'd2, 32'd0);
      end
    end
    checks++;
    if (gap !== 2) begin failures++; $display("FAIL b2b_same_gap got=%0d want=2", gap); end
    checks++;
    if (first_rd !== 32'h10 || bus.rdata0 !== 32'd0 || ndone !== 2)
      begin failures++; $display("FAIL b2b_same_data got=%0h,%0h n=%0d want=10,0 n=2", first_rd, bus.rdata0, ndone); end
  endtask

  task automatic test_round_robin;
    int order[$];
    int dorder[$];
    int exp_order[4] = '{0, 1, 0, 1};
    int idx0 = 0, idx1 = 0, overlap = 0, cyc = 0, last_done = -1, bad_gap = 0;
    bit pg0 = 1'b0, pg1 = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    drive_cmd(0, 1'b1, 1'b1, 4'd0, 32'h55);
    drive_cmd(1, 1'b1, 1'b0, 4'd1, 32'd0);
    for (int n = 0; n < 200 && (idx0 < 2 || idx1 < 2); n++) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt0 && bus.gnt1) overlap++;
      if ((bus.gnt0 && !pg0) || (bus.gnt1 && !pg1)) begin
        order.push_back(bus.gnt1 ? 1 : 0);
        if (last_done >= 0 && cyc - last_done != 1) bad_gap++;
      end
      pg0 = bus.gnt0;
      pg1 = bus.gnt1;
      if (bus.done0) begin
        dorder.push_back(0); idx0++; last_done = cyc;
        if (idx0 < 2) drive_cmd(0, 1'b1, 1'b0, 4'd0, 32'd0); else drive_cmd(0, 1'b0, 1'b0, 4'd0, 32'd0);
      end
      if (bus.done1) begin
        dorder.push_back(1); idx1++; last_done = cyc;
        if (idx1 < 2) drive_cmd(1, 1'b1, 1'b0, 4'd2, 32'd0); else drive_cmd(1, 1'b0, 1'b0, 4'd2, 32'd0);
      end
    end
    checks++;
    if (order.size() !== 4) begin failures++; $display("FAIL rr_grant_count got=%0d want=4", order.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) begin
        checks++;
        if (order[i] !== exp_order[i]) begin failures++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]); end
      end
    end
    checks++;
    if (overlap !== 0) begin failures++; $display("FAIL rr_overlap got=%0d want=0", overlap); end
    for (int i = 1; i < dorder.size(); i++) begin
      checks++;
      if (dorder[i] === dorder[i-1]) begin failures++; $display("FAIL rr_done_alt[%0d] got=%0d want=%0d", i, dorder[i], 1 - dorder[i-1]); end
    end
    checks++;
    if (bad_gap !== 0) begin failures++; $display("FAIL rr_no_dead_cycle got=%0d want=0", bad_gap); end
    checks++;
    if (bus.rdata0 !== 32'h55) begin failures++; $display("FAIL rr_read_back got=%0h want=55", bus.rdata0); end
  endtask

  task automatic test_timeout;
    int lat = 0, ndone = 0;
    b4_waits = 4;
    @(negedge clk);
    bus4.req0 = 1'b1; bus4.wr0 = 1'b0; bus4.addr0 = 4'd0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (bus4.done0) begin lat = n; break; end
    end
    bus4.req0 = 1'b0;
    checks++;
    if (lat !== 7 || bus4.err0 !== 1'b0 || bus4.rdata0 !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL to_ready_wins lat=%0d err=%b rdata=%0h want 7/0/deadbeef", lat, bus4.err0, bus4.rdata0); end
    b4_waits = -1;
    lat = 0;
    @(negedge clk);
    bus4.req0 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (bus4.done0) begin lat = n; break; end
    end
    bus4.req0 = 1'b0;
    checks++;
    if (lat !== 7) begin failures++; $display("FAIL to_abort_latency got=%0d want=7", lat); end
    checks++;
    if (bus4.err0 !== 1'b1 || bus4.rdata0 !== 32'd0)
      begin failures++; $display("FAIL to_abort_resp err=%b rdata=%0h want 1/0", bus4.err0, bus4.rdata0); end
    @(negedge clk);
    checks++;
    if ({bus4.PSEL, bus4.PENABLE, bus4.gnt0, bus4.done0, bus4.err0} !== 5'b0)
      begin failures++; $display("FAIL to_idle got=%b want=00000", {bus4.PSEL, bus4.PENABLE, bus4.gnt0, bus4.done0, bus4.err0}); end
    @(negedge clk);
    bus0.req0 = 1'b1; bus0.wr0 = 1'b0; bus0.addr0 = 4'd3;
    repeat (100) begin
      @(negedge clk);
      if (bus0.done0) ndone++;
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL to_disabled_done got=%0d want=0", ndone); end
    checks++;
    if ({bus0.PSEL, bus0.PENABLE} !== 2'b11)
      begin failures++; $display("FAIL to_disabled_access got=%b want=11", {bus0.PSEL, bus0.PENABLE}); end
    bus0.req0 = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat, nd = 0;
    bit seen = 1'b0, dn0 = 1'b0, dn1 = 1'b0;
    run_req(0, 1'b1, 4'd1, 32'd0, lat);
    cfg_waits = 10;
    @(negedge clk);
    drive_cmd(0, 1'b1, 1'b0, 4'd0, 32'd0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.PSEL && bus.PENABLE) begin seen = 1'b1; break; end
    end
    drive_cmd(1, 1'b1, 1'b0, 4'd2, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({seen, bus.PSEL, bus.PENABLE, bus.gnt0, bus.gnt1} !== 5'b10000)
      begin failures++; $display("FAIL rstmid_drop got=%b want=10000", {seen, bus.PSEL, bus.PENABLE, bus.gnt0, bus.gnt1}); end
    repeat (2) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) nd++;
    end
    checks++;
    if (nd !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", nd); end
    cfg_waits = 0;
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) break;
    end
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10)
      begin failures++; $display("FAIL rstmid_tie got gnt0/1=%b want=10", {bus.gnt0, bus.gnt1}); end
    for (int n = 0; n < 60 && !(dn0 && dn1); n++) begin
      @(negedge clk);
      if (bus.done0) begin dn0 = 1'b1; drive_cmd(0, 1'b0, 1'b0, 4'd0, 32'd0); end
      if (bus.done1) begin dn1 = 1'b1; drive_cmd(1, 1'b0, 1'b0, 4'd2, 32'd0); end
    end
    checks++;
    if ({dn0, dn1} !== 2'b11) begin failures++; $display("FAIL rstmid_complete got=%b want=11", {dn0, dn1}); end
  endtask

  task automatic test_random;
    logic [31:0] m [0:3];
    logic [31:0] exp_rd [0:1];
    int remaining [0:1];
    int gap [0:1];
    bit cw [0:1];
    logic [3:0] ca [0:1];
    logic [31:0] cd [0:1];
    bit d_now [0:1];
    bit rq;
    int lat, overlap = 0, doubles = 0;
    logic [31:0] got;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    rand_waits = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_req(0, 1'b1, 4'(i), 32'd0, lat);
      m[i] = '0;
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int r = 0; r < 2; r++) begin remaining[r] = 15; gap[r] = 0; end
    for (int n = 0; n < 3000 && (remaining[0] > 0 || remaining[1] > 0); n++) begin
      @(negedge clk);
      if (bus.gnt0 && bus.gnt1) overlap++;
      if (bus.done0 && bus.done1) doubles++;
      d_now[0] = bus.done0;
      d_now[1] = bus.done1;
      for (int r = 0; r < 2; r++) begin
        rq = (r == 0) ? bus.req0 : bus.req1;
        if (d_now[r]) begin
          checks++;
          if (((r == 0) ? bus.err0 : bus.err1) !== 1'b0)
            begin failures++; $display("FAIL rand_err r%0d got=1 want=0", r); end
          if (!cw[r]) exp_rd[r] = m[ca[r]];
          else begin
            m[ca[r]] = cd[r];
            if (ca[r] == 4'd1 && cd[r][0]) m[3] = m[0];
          end
          got = (r == 0) ? bus.rdata0 : bus.rdata1;
          checks++;
          if (got !== exp_rd[r])
            begin failures++; $display("FAIL rand_rdata r%0d wr=%b addr=%0d got=%0h want=%0h", r, cw[r], ca[r], got, exp_rd[r]); end
          remaining[r]--;
          if (remaining[r] > 0 && $urandom_range(0, 1) == 0) new_cmd(r, cw[r], ca[r], cd[r]);
          else begin
            drive_cmd(r, 1'b0, cw[r], ca[r], cd[r]);
            gap[r] = int'($urandom_range(0, 2));
          end
        end else if (!rq && remaining[r] > 0) begin
          if (gap[r] == 0) new_cmd(r, cw[r], ca[r], cd[r]);
          else gap[r]--;
        end
      end
    end
    rand_waits = 1'b0;
    checks++;
    if (remaining[0] !== 0 || remaining[1] !== 0)
      begin failures++; $display("FAIL rand_timeout left=%0d,%0d want=0,0", remaining[0], remaining[1]); end
    checks++;
    if (overlap !== 0 || doubles !== 0)
      begin failures++; $display("FAIL rand_exclusive overlap=%0d doubles=%0d want=0", overlap, doubles); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive_cmd(0, 1'b0, 1'b0, 4'd0, 32'd0);
    drive_cmd(1, 1'b0, 1'b0, 4'd0, 32'd0);
    bus4.req0 = 1'b0; bus4.req1 = 1'b0; bus4.wr0 = 1'b0; bus4.wr1 = 1'b0;
    bus4.addr0 = '0; bus4.addr1 = '0; bus4.wdata0 = '0; bus4.wdata1 = '0;
    bus4.PRDATA = 32'hDEAD_BEEF;
    bus0.req0 = 1'b0; bus0.req1 = 1'b0; bus0.wr0 = 1'b0; bus0.wr1 = 1'b0;
    bus0.addr0 = '0; bus0.addr1 = '0; bus0.wdata0 = '0; bus0.wdata1 = '0;
    bus0.PRDATA = 32'h1234_5678;
    bus0.PREADY = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_wait_states;
    test_back_to_back;
    test_round_robin;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_counter_arbiter.md
# apb_counter_arbiter

Two-port APB master that shares a single APB counter slave (load-value, load, enable, count registers at PADDR 0-3) between two independent requesters. Each requester posts a single read or write command; the block arbitrates round-robin, runs a standard SETUP/ACCESS APB transfer, returns read data and a completion pulse, and aborts transfers whose PREADY never arrives.

## Interface
Parameters:
- TIMEOUT, 8'd16: maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req0 / req1  input  1  command request from requester 0 / 1, held until its done
- wr0 / wr1  input  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  input  4  register address; stable while req high
- wdata0 / wdata1  input  32  write data; stable while req high
- gnt0 / gnt1  output  1  high while the requester's transfer occupies the bus (SETUP and ACCESS)
- done0 / done1  output  1  one-cycle completion pulse
- err0 / err1  output  1  valid with done; 1 = timeout abort
- rdata0 / rdata1  output  32  read data, valid with done, held until that requester's next done
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  4  APB address
- PWDATA  output  32  APB write data
- PRDATA  input  32  APB read data
- PREADY  input  1  APB ready, sampled only in ACCESS

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: eligible requesters are those with req high and done low this cycle (masks stale req on the done cycle). If none are eligible, stay in IDLE. Otherwise pick a winner, latch its wr/addr/wdata into PWRITE/PADDR/PWDATA, and go to SETUP.
- Arbitration is round-robin. With a single eligible requester, it wins. With both eligible, the requester not served last wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
- SETUP: PSEL=1, PENABLE=0. Always advance to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - If PREADY=1: complete. Pulse done for the winner with err=0. For a read, capture PRDATA into that requester's rdata. A write leaves rdata unchanged. Go to IDLE.
  - If PREADY=0: increment the wait counter (8-bit, cleared on entering SETUP). If TIMEOUT≠0 and the counter reaches TIMEOUT, abort: done=1, err=1, rdata forced to 0, go to IDLE.
- PREADY=1 and the timeout threshold in the same cycle: PREADY wins, normal completion.
- PWRITE/PADDR/PWDATA hold their last values in IDLE. PSEL/PENABLE are 0 in IDLE.
- Only one gnt is high at a time. Only one done is pulsed per transfer.
- The requester deasserts req on done, or may keep req high to issue its next command. That command becomes eligible one cycle after done.

## Timing
- All outputs registered.
- Reset values: PSEL, PENABLE, PWRITE = 0; PADDR = 0; PWDATA = 0; gnt*, done*, err* = 0; rdata* = 0; state = IDLE; last-served = 1; wait counter = 0.
- Reset assertion mid-transfer: outputs return to reset values immediately (asynchronous), no done is issued, and the transfer is lost.
- Zero-wait transfer, with req high at edge k in IDLE:
  - cycle k+1: SETUP, gnt=1
  - cycle k+2: ACCESS, PREADY=1
  - cycle k+3: IDLE, done=1
- Per transfer: 3 cycles plus N wait cycles.
- Other-requester back-to-back: SETUP at the cycle after done, so no dead cycle beyond IDLE.
- Same-requester back-to-back: one extra IDLE cycle (done mask).
- Timeout abort: done/err at cycle k+3+TIMEOUT when PREADY stays low.

## Test plan
- Reset, then req0 write addr0 wdata 0x0000_0010 with PREADY=1 in ACCESS:
  - PSEL/PENABLE sequence is 1/0 then 1/1
  - PADDR=0, PWDATA=0x10
  - done0 at k+3, err0=0
- Read: write addr1=1 (load), then addr1=0, addr2=1 (enable); after 5 idle cycles, req1 read addr3:
  - rdata1 equals the counter value captured at the ACCESS edge (≥0x10)
  - done1 pulses once
- Both req0 and req1 asserted the same cycle after reset, each with 2 commands:
  - grant order 0,1,0,1
  - no cycle with both gnt high
  - done pulses alternate
- Slave holds PREADY=0 in ACCESS for 3 cycles, TIMEOUT=16: done at k+6, err=0, correct rdata.
- PREADY held low, TIMEOUT=4: abort with done=1, err=1, rdata=0 at k+7, state back to IDLE. Repeat with TIMEOUT=0: no abort after 100 cycles.
- Assert rst during ACCESS: PSEL/PENABLE/gnt drop the same cycle, no done. After release, the pending req is re-arbitrated with requester 0 winning the tie.
